// File: rtl/updown_counter.sv
// Up/down counter with wrap or saturate behaviour, parallel load, sticky
// overflow/underflow flags and a combinational terminal-count flag.
module updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH:0]   StepExt  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MaxVal   = '1;
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH:0]   up_sum, dn_diff;
  logic             up_cross, dn_cross;
  logic             set_ov, set_un;

  // One extra bit keeps the carry/borrow that marks a limit crossing.
  always_comb begin
    up_sum   = {1'b0, count_q} + StepExt;
    dn_diff  = {1'b0, count_q} - StepExt;
    up_cross = up_sum[WIDTH];
    dn_cross = dn_diff[WIDTH];
  end

  always_comb begin
    count_d = count_q;
    set_ov  = 1'b0;
    set_un  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir) begin
        set_ov  = up_cross;
        count_d = (up_cross && sat_mode) ? MaxVal : up_sum[WIDTH-1:0];
      end else begin
        set_un  = dn_cross;
        count_d = (dn_cross && sat_mode) ? '0 : dn_diff[WIDTH-1:0];
      end
    end
    // A set event in the same cycle as a clear wins.
    overflow_d  = (overflow_q & ~clr_flags) | set_ov;
    underflow_d = (underflow_q & ~clr_flags) | set_un;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= ResetVal;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    count     = count_q;
    overflow  = overflow_q;
    underflow = underflow_q;
    tc        = ~reset & en & ~load & (dir ? up_cross : dn_cross);
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: four parameterisations share stimulus and are
// compared against a behavioural model through a scoreboard queue.
module tb_updown_counter;

  logic        clock = 1'b0;
  logic        reset, en, dir, sat_mode, load, clr_flags;
  logic [15:0] lv16;

  logic [7:0]  c0, c1;
  logic [3:0]  c2;
  logic [15:0] c3;
  logic        tc0, tc1, tc2, tc3;
  logic        ov0, ov1, ov2, ov3;
  logic        un0, un1, un2, un3;

  updown_counter #(.WIDTH(8), .STEP(1), .RESET_VAL(0)) u0 (
    .clock(clock), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode), .load(load),
    .load_val(lv16[7:0]), .clr_flags(clr_flags), .count(c0), .tc(tc0), .overflow(ov0),
    .underflow(un0));
  updown_counter #(.WIDTH(8), .STEP(3), .RESET_VAL(0)) u1 (
    .clock(clock), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode), .load(load),
    .load_val(lv16[7:0]), .clr_flags(clr_flags), .count(c1), .tc(tc1), .overflow(ov1),
    .underflow(un1));
  updown_counter #(.WIDTH(4), .STEP(5), .RESET_VAL(7)) u2 (
    .clock(clock), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode), .load(load),
    .load_val(lv16[3:0]), .clr_flags(clr_flags), .count(c2), .tc(tc2), .overflow(ov2),
    .underflow(un2));
  updown_counter #(.WIDTH(16), .STEP(5), .RESET_VAL(7)) u3 (
    .clock(clock), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode), .load(load),
    .load_val(lv16), .clr_flags(clr_flags), .count(c3), .tc(tc3), .overflow(ov3),
    .underflow(un3));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int W  [4] = '{8, 8, 4, 16};
  int ST [4] = '{1, 3, 5, 5};
  int RV [4] = '{0, 0, 7, 7};

  int m_cnt [4];
  bit m_ov  [4];
  bit m_un  [4];

  typedef struct packed {
    logic [3:0][15:0] cnt;
    logic [3:0]       ov;
    logic [3:0]       un;
  } exp_t;
  exp_t sb[$];

  // ctl = {reset, en, dir, sat_mode, load, clr_flags}; x_f = {overflow, underflow, tc}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [15:0] lv;
    logic [15:0] x_cnt;
    logic [2:0]  x_f;
  } vec_t;
  vec_t tbl [17];

  function automatic int dut_cnt(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  function automatic int dut_tc(int i);
    case (i)
      0: return int'(tc0);
      1: return int'(tc1);
      2: return int'(tc2);
      default: return int'(tc3);
    endcase
  endfunction

  function automatic int dut_ov(int i);
    case (i)
      0: return int'(ov0);
      1: return int'(ov1);
      2: return int'(ov2);
      default: return int'(ov3);
    endcase
  endfunction

  function automatic int dut_un(int i);
    case (i)
      0: return int'(un0);
      1: return int'(un1);
      2: return int'(un2);
      default: return int'(un3);
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic int model_tc(int i, bit r, bit e, bit d, bit l);
    int mx = (1 << W[i]) - 1;
    if (r || !e || l) return 0;
    if (d) return (m_cnt[i] > mx - ST[i]) ? 1 : 0;
    return (m_cnt[i] < ST[i]) ? 1 : 0;
  endfunction

  task automatic model_step(input int i, input bit r, input bit e, input bit d, input bit s,
                            input bit l, input bit c, input int lv);
    int mx = (1 << W[i]) - 1;
    bit so = 0;
    bit su = 0;
    if (r) begin
      m_cnt[i] = RV[i];
      m_ov[i]  = 0;
      m_un[i]  = 0;
    end else begin
      if (l) begin
        m_cnt[i] = lv & mx;
      end else if (e && d) begin
        if (m_cnt[i] + ST[i] > mx) begin
          so       = 1;
          m_cnt[i] = s ? mx : m_cnt[i] + ST[i] - (mx + 1);
        end else begin
          m_cnt[i] = m_cnt[i] + ST[i];
        end
      end else if (e) begin
        if (m_cnt[i] < ST[i]) begin
          su       = 1;
          m_cnt[i] = s ? 0 : m_cnt[i] - ST[i] + (mx + 1);
        end else begin
          m_cnt[i] = m_cnt[i] - ST[i];
        end
      end
      m_ov[i] = (m_ov[i] && !c) || so;
      m_un[i] = (m_un[i] && !c) || su;
    end
  endtask

  // Drive one cycle; tc is checked before the edge, state after it via the scoreboard.
  task automatic cycle(input bit r, input bit e, input bit d, input bit s, input bit l,
                       input bit c, input int lv, output int tc0_o);
    exp_t x;
    reset     = r;
    en        = e;
    dir       = d;
    sat_mode  = s;
    load      = l;
    clr_flags = c;
    lv16      = 16'(lv);
    #1;
    tc0_o = int'(tc0);
    for (int i = 0; i < 4; i++) chk("tc", i, dut_tc(i), model_tc(i, r, e, d, l));
    for (int i = 0; i < 4; i++) begin
      model_step(i, r, e, d, s, l, c, lv);
      x.cnt[i] = 16'(m_cnt[i]);
      x.ov[i]  = m_ov[i];
      x.un[i]  = m_un[i];
    end
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      chk("count", i, dut_cnt(i), int'(x.cnt[i]));
      chk("overflow", i, dut_ov(i), int'(x.ov[i]));
      chk("underflow", i, dut_un(i), int'(x.un[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int exp36_cnt [5] = '{254, 255, 255, 255, 255};
    int exp36_ov  [5] = '{0, 0, 1, 1, 1};

    //              ctl (r e d s l c)  lv       cnt      {ov,un,tc}
    tbl[0]  = '{6'b110010, 16'h0040, 16'h0000, 3'b000};
    tbl[1]  = '{6'b010010, 16'h0040, 16'h0040, 3'b000};
    tbl[2]  = '{6'b011000, 16'h0000, 16'h0041, 3'b000};
    tbl[3]  = '{6'b010000, 16'h0000, 16'h0040, 3'b000};
    tbl[4]  = '{6'b000000, 16'h0000, 16'h0040, 3'b000};
    tbl[5]  = '{6'b000010, 16'h0000, 16'h0000, 3'b000};
    tbl[6]  = '{6'b010000, 16'h0000, 16'h00ff, 3'b011};
    tbl[7]  = '{6'b011001, 16'h0000, 16'h0000, 3'b101};
    tbl[8]  = '{6'b000010, 16'h00ff, 16'h00ff, 3'b100};
    tbl[9]  = '{6'b011100, 16'h0000, 16'h00ff, 3'b101};
    tbl[10] = '{6'b000001, 16'h0000, 16'h00ff, 3'b000};
    tbl[11] = '{6'b011100, 16'h0000, 16'h00ff, 3'b101};
    tbl[12] = '{6'b000011, 16'h0001, 16'h0001, 3'b000};
    tbl[13] = '{6'b010100, 16'h0000, 16'h0000, 3'b000};
    tbl[14] = '{6'b010100, 16'h0000, 16'h0000, 3'b011};
    tbl[15] = '{6'b011000, 16'h0000, 16'h0001, 3'b010};
    tbl[16] = '{6'b110001, 16'h0000, 16'h0000, 3'b000};

    for (int k = 0; k < 17; k++) begin
      cycle(tbl[k].ctl[5], tbl[k].ctl[4], tbl[k].ctl[3], tbl[k].ctl[2], tbl[k].ctl[1],
            tbl[k].ctl[0], int'(tbl[k].lv), t);
      chk("tbl_tc", k, t, int'(tbl[k].x_f[0]));
      chk("tbl_count", k, int'(c0), int'(tbl[k].x_cnt));
      chk("tbl_overflow", k, int'(ov0), int'(tbl[k].x_f[2]));
      chk("tbl_underflow", k, int'(un0), int'(tbl[k].x_f[1]));
    end

    // Full up-count ramp with wrap.
    cycle(1, 0, 0, 0, 0, 0, 0, t);
    for (int k = 0; k < 256; k++) begin
      cycle(0, 1, 1, 0, 0, 0, 0, t);
      chk("ramp_tc", k, t, (k == 255) ? 1 : 0);
      chk("ramp_ov", k, int'(ov0), (k == 255) ? 1 : 0);
    end
    chk("ramp_wrap", 0, int'(c0), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, t);
    chk("ramp_ov_sticky", 0, int'(ov0), 1);

    // Saturating approach to the top from 253.
    cycle(0, 0, 0, 1, 1, 1, 253, t);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 1, 1, 0, 0, 0, t);
      chk("sat_count", k, int'(c0), exp36_cnt[k]);
      chk("sat_ov", k, int'(ov0), exp36_ov[k]);
    end

    // STEP=3 borrow from 2: wrap then clamp.
    cycle(0, 0, 0, 0, 1, 1, 2, t);
    cycle(0, 1, 0, 0, 0, 0, 0, t);
    chk("s3_wrap_count", 0, int'(c1), 255);
    chk("s3_wrap_un", 0, int'(un1), 1);
    cycle(0, 0, 0, 1, 1, 1, 2, t);
    cycle(0, 1, 0, 1, 0, 0, 0, t);
    chk("s3_clamp_count", 0, int'(c1), 0);
    chk("s3_clamp_un", 0, int'(un1), 1);

    // Set beats clear in the same cycle; clear alone then drops the flag.
    cycle(0, 0, 0, 0, 1, 1, 2, t);
    cycle(0, 1, 0, 0, 0, 1, 0, t);
    chk("setclr_un", 0, int'(un1), 1);
    cycle(0, 0, 0, 0, 0, 1, 0, t);
    chk("clr_un", 0, int'(un1), 0);
    chk("clr_count", 0, int'(c1), 255);

    // Random traffic against the model on all instances.
    cycle(1, 0, 0, 0, 0, 0, 0, t);
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 65535)), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
